toggle_cover_arbiter: RTL and testbench
=======================================

# toggle_cover_arbiter

Collects single-cycle hit pulses from a bank of toggle-coverage points and serialises them into one valid/ready stream of cover indices for the coverage reporter. Per-point pending bits absorb hits, and a round-robin arbiter grants one pending point per cycle into a small FIFO. An optional reported-bitmap suppresses repeat reports of the same point until software re-arms it. The block sits between the per-signal toggle cover points and the single reporting port, replacing one reporter call per point per cycle.

## Interface
- NUM_REQ, 8: number of cover points in the bank (2..64).
- BASE_INDEX, 0: cover index of point 0; point i reports BASE_INDEX+i.
- IDX_W, 14: width of emitted cover index (covers COVER_TOTAL 8940).
- FIFO_DEPTH, 4: output FIFO entries (power of two, ≥2).
- DEDUP, 1: 1 = report each point once until re-armed; 0 = report every hit.
- clock  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- hit  in  NUM_REQ  per-point hit pulse; bit i = point i toggled this cycle.
- clear_reported  in  1  pulse; re-arms all points (DEDUP=1 only).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  reporter accepts head.
- out_index  out  IDX_W  BASE_INDEX + point id of head.
- drop_count  out  32  hits absorbed without a new report; saturating.
- report_count  out  32  entries popped (out_valid && out_ready); saturating.

## Operation
- State: pending[NUM_REQ], reported[NUM_REQ], rr_ptr (log2 NUM_REQ), FIFO (ids + count), two counters.
- Accept: hit[i] sets pending[i] next cycle unless blocked. Blocked when pending[i] already 1 (and not granted this cycle), or DEDUP=1 and reported[i]=1 (or granted this cycle). Each blocked hit bit adds 1 to drop_count; multiple per cycle add their popcount.
- Grant: when FIFO count < FIFO_DEPTH and any pending, pick first pending id searching rr_ptr, rr_ptr+1, … wrapping mod NUM_REQ. Granted id pushed to FIFO; pending[id] cleared; reported[id] set (DEDUP=1); rr_ptr <= (id+1) mod NUM_REQ. At most one grant per cycle. No grant → rr_ptr holds.
- Grant eligibility uses count at start of cycle only; a simultaneous pop does not free a slot for this cycle's grant.
- Hit on a point in the same cycle it is granted: DEDUP=1 → dropped (counted). DEDUP=0 → pending[i] re-set (new event, not counted).
- clear_reported: all reported bits 0 next cycle; takes priority over a same-cycle grant's set. Pending and FIFO untouched. Ignored when DEDUP=0 (reported held 0).
- Pop: out_valid && out_ready removes head; report_count += 1. Push and pop in one cycle both take effect; count unchanged.
- Counters saturate at 0xFFFF_FFFF, never wrap.
- out_index width: BASE_INDEX+id computed at IDX_W, truncated; BASE_INDEX+NUM_REQ-1 must be < 2^IDX_W (elaboration-time check under `ifndef SYNTHESIS`).

## Timing
- Reset (synchronous): pending=0, reported=0, rr_ptr=0, FIFO empty, out_valid=0, out_index=0, drop_count=0, report_count=0. Hits in reset cycle ignored. Reset mid-stream discards all queued entries.
- Latency: hit at cycle t → pending at t+1 → granted at t+1 if first in RR order and space → out_valid=1 at t+2.
- out_index/out_valid registered from FIFO storage; stable while out_valid && !out_ready.
- Throughput: one report per cycle with out_ready=1.
- Full FIFO: grants stall, pending bits accumulate, new hits on pending points counted as drops.

## Test plan
- Reset then hit=0x01 one cycle, out_ready=1 → out_valid at cycle 2, out_index=BASE_INDEX; report_count=1; drop_count=0.
- hit=0xFF one cycle, out_ready=1, rr_ptr=0 → indices 0..7 in order, one per cycle, starting cycle 2; rr_ptr ends 0.
- DEDUP=1: hit[3] three separate times → one report of 3, drop_count=2; pulse clear_reported, hit[3] again → second report of 3.
- out_ready=0, hit=0xFF → FIFO holds 0,1,2,3, out_valid stuck with out_index=0; pending 4..7 held; repeat hit=0xFF → drop_count=8; release out_ready → 0..7 emitted, total 8.
- DEDUP=0: hit[2] in the cycle point 2 is granted → two reports of 2, drop_count=0.
- Reset asserted with 3 entries queued → next cycle out_valid=0, both counters 0, subsequent hit[5] reported normally.

Source files
------------

// File: rtl/toggle_cover_arbiter.sv
// Serialises toggle-cover hit pulses into one valid/ready stream of cover indices.
// Per-point pending bits feed a round-robin grant into a small output FIFO.
module toggle_cover_arbiter #(
  parameter int NUM_REQ    = 8,
  parameter int BASE_INDEX = 0,
  parameter int IDX_W      = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int DEDUP      = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] hit,
  input  logic               clear_reported,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_index,
  output logic [31:0]        drop_count,
  output logic [31:0]        report_count
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

`ifndef SYNTHESIS
  if (longint'(BASE_INDEX) + longint'(NUM_REQ) - 1 >= (longint'(1) << IDX_W)) begin : g_idx_check
    $error("toggle_cover_arbiter: BASE_INDEX+NUM_REQ-1 does not fit in IDX_W bits");
  end
`endif

  logic [NUM_REQ-1:0] pending_reg, pending_next;
  logic [NUM_REQ-1:0] reported_reg, reported_next;
  logic [NUM_REQ-1:0] grant_onehot, blocked;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next, grant_id;
  logic               grant_valid;
  logic [IDX_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic               push, pop;
  logic [31:0]        drop_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Walk offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (count_reg < CW'(FIFO_DEPTH)) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (pending_reg[PTR_W'(idx)]) begin
          grant_valid = 1'b1;
          grant_id    = PTR_W'(idx);
        end
      end
    end
  end

  // Grant is applied first: a hit on the granted point is a new event unless deduplicating.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_point
    assign grant_onehot[gi]  = grant_valid && (grant_id == PTR_W'(gi));
    assign blocked[gi]       = hit[gi] && ((pending_reg[gi] && !grant_onehot[gi]) ||
                               ((DEDUP != 0) && (reported_reg[gi] || grant_onehot[gi])));
    assign pending_next[gi]  = (hit[gi] && !blocked[gi]) || (pending_reg[gi] && !grant_onehot[gi]);
    assign reported_next[gi] = ((DEDUP == 0) || clear_reported) ? 1'b0
                               : (reported_reg[gi] || grant_onehot[gi]);
  end

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop_inc = drop_inc + 32'(blocked[i]);
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
    end
  end

  assign push      = grant_valid;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count_reg != '0);
  assign out_index = out_valid ? fifo_mem[rd_ptr_reg] : '0;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= IDX_W'(BASE_INDEX) + IDX_W'(grant_id);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg  <= '0;
      reported_reg <= '0;
      rr_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_count   <= '0;
      report_count <= '0;
    end else begin
      pending_reg  <= pending_next;
      reported_reg <= reported_next;
      rr_ptr_reg   <= rr_ptr_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      drop_count   <= sat_add(drop_count, drop_inc);
      report_count <= sat_add(report_count, {31'd0, pop});
    end
  end
endmodule

// File: tb/tb_toggle_cover_arbiter.sv
// Bench for toggle_cover_arbiter: a DEDUP=1 and a DEDUP=0 instance share stimulus; a
// per-instance reference model feeds expected indices to negedge monitors.
module tb_toggle_cover_arbiter;
  localparam int N     = 8;
  localparam int BASE  = 40;
  localparam int IW    = 14;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  hit = '0;
  logic          clear_reported = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    ov;
  logic [IW-1:0] oi [2];
  logic [31:0]   dc [2];
  logic [31:0]   rc [2];

  always #5 clock = ~clock;

  toggle_cover_arbiter #(.NUM_REQ(N), .BASE_INDEX(BASE), .IDX_W(IW), .FIFO_DEPTH(DEPTH), .DEDUP(1)) u_dedup (
    .clock(clock), .reset(reset), .hit(hit), .clear_reported(clear_reported),
    .out_valid(ov[0]), .out_ready(out_ready), .out_index(oi[0]),
    .drop_count(dc[0]), .report_count(rc[0]));

  toggle_cover_arbiter #(.NUM_REQ(N), .BASE_INDEX(BASE), .IDX_W(IW), .FIFO_DEPTH(DEPTH), .DEDUP(0)) u_every (
    .clock(clock), .reset(reset), .hit(hit), .clear_reported(clear_reported),
    .out_valid(ov[1]), .out_ready(out_ready), .out_index(oi[1]),
    .drop_count(dc[1]), .report_count(rc[1]));

  int     checks = 0;
  int     errors = 0;
  int     exp_q [2][$];
  bit     pend [2][N];
  bit     repd [2][N];
  int     rr [2];
  int     cnt [2];
  longint drops [2];
  longint reps [2];
  bit     armed = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: instance 0 deduplicates, instance 1 reports every hit.
  task automatic model_step(input int m, input logic [N-1:0] h, input logic clr,
                            input logic rdy, input logic rst);
    int start_cnt;
    int gid;
    int id;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pend[m][i] = 1'b0;
        repd[m][i] = 1'b0;
      end
      rr[m] = 0; cnt[m] = 0; drops[m] = 0; reps[m] = 0;
      exp_q[m].delete();
      return;
    end
    start_cnt = cnt[m];
    if (cnt[m] > 0 && rdy) begin
      cnt[m]--;
      reps[m]++;
    end
    gid = -1;
    if (start_cnt < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        id = (rr[m] + k) % N;
        if (gid < 0 && pend[m][id]) gid = id;
      end
    end
    if (gid >= 0) begin
      pend[m][gid] = 1'b0;
      if (m == 0) repd[m][gid] = 1'b1;
      exp_q[m].push_back(BASE + gid);
      cnt[m]++;
      rr[m] = (gid + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (h[i]) begin
        if (pend[m][i] || repd[m][i]) drops[m]++;
        else pend[m][i] = 1'b1;
      end
    end
    if (clr) begin
      for (int i = 0; i < N; i++) repd[m][i] = 1'b0;
    end
  endtask

  task automatic cycle(input logic [N-1:0] h, input logic clr, input logic rdy, input logic rst);
    @(posedge clock);
    #1;
    if (armed) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("valid%0d", m), longint'(ov[m]), longint'(cnt[m] > 0));
        chk($sformatf("drop_count%0d", m), longint'(dc[m]), drops[m]);
        chk($sformatf("report_count%0d", m), longint'(rc[m]), reps[m]);
      end
    end
    hit = h; clear_reported = clr; out_ready = rdy; reset = rst;
    for (int m = 0; m < 2; m++) model_step(m, h, clr, rdy, rst);
    if (rst) armed = 1'b1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 1'b0, 1'b1);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    int e;
    always @(negedge clock) begin
      if (!reset && ov[gi] && out_ready) begin
        checks++;
        if (exp_q[gi].size() == 0) begin
          errors++;
          $display("FAIL pop%0d: got index %0d, expected no entry", gi, oi[gi]);
        end else begin
          e = exp_q[gi].pop_front();
          if (int'(oi[gi]) != e) begin
            errors++;
            $display("FAIL pop%0d: got index %0d, expected %0d", gi, oi[gi], e);
          end else begin
            $display("pop dut%0d index=%0d", gi, oi[gi]);
          end
        end
      end
    end
  end

  initial begin
    // single hit, latency
    do_reset();
    cycle(8'h01, 1'b0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    chk("latency_not_yet", longint'(ov[0]), 0);
    cycle('0, 1'b0, 1'b1, 1'b0);
    chk("latency_valid", longint'(ov[0]), 1);
    chk("first_index", longint'(oi[0]), BASE);
    idle(3, 1'b1);
    chk("t1_reports", longint'(rc[0]), 1);
    chk("t1_drops", longint'(dc[0]), 0);

    // all points at once
    do_reset();
    cycle(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(11, 1'b1);
    chk("t2_reports", longint'(rc[0]), 8);

    // repeat hits with dedup and re-arm
    do_reset();
    for (int r = 0; r < 3; r++) begin
      cycle(8'h08, 1'b0, 1'b1, 1'b0);
      idle(4, 1'b1);
    end
    chk("t3_dedup_drops", longint'(dc[0]), 2);
    chk("t3_dedup_reports", longint'(rc[0]), 1);
    chk("t3_every_reports", longint'(rc[1]), 3);
    cycle('0, 1'b1, 1'b1, 1'b0);
    cycle(8'h08, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("t3_rearm_reports", longint'(rc[0]), 2);

    // full FIFO stall
    do_reset();
    cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("t4_stuck_valid", longint'(ov[0]), 1);
    chk("t4_stuck_index", longint'(oi[0]), BASE);
    cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("t4_dedup_drops", longint'(dc[0]), 8);
    chk("t4_every_drops", longint'(dc[1]), 4);
    idle(20, 1'b1);
    chk("t4_dedup_reports", longint'(rc[0]), 8);
    chk("t4_every_reports", longint'(rc[1]), 12);

    // hit in the same cycle as its grant
    do_reset();
    cycle(8'h04, 1'b0, 1'b1, 1'b0);
    cycle(8'h04, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);
    chk("t5_every_reports", longint'(rc[1]), 2);
    chk("t5_every_drops", longint'(dc[1]), 0);
    chk("t5_dedup_reports", longint'(rc[0]), 1);
    chk("t5_dedup_drops", longint'(dc[0]), 1);

    // reset with entries queued
    do_reset();
    cycle(8'h07, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("t6_queued_valid", longint'(ov[0]), 1);
    do_reset();
    cycle('0, 1'b0, 1'b1, 1'b0);
    chk("t6_valid_cleared", longint'(ov[0]), 0);
    chk("t6_drops_cleared", longint'(dc[0]), 0);
    chk("t6_reports_cleared", longint'(rc[0]), 0);
    cycle(8'h20, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("t6_after_reports", longint'(rc[0]), 1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] h;
      h = ($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      cycle(h, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 299) == 0));
    end

    // bounded drain
    for (int c = 0; c < 60 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); c++) begin
      idle(1, 1'b1);
    end
    idle(2, 1'b1);
    chk("drain_left0", exp_q[0].size(), 0);
    chk("drain_left1", exp_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
